// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: program-counter handshake, instruction memory read port
// and the decode-side buffer head.
interface instruction_fetch_if;
  logic [31:0] pc_in;
  logic        pc_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_misalign;

  modport master (
    input  pc_in, flush, mem_rvalid, mem_rdata, instr_ready,
    output pc_stall, mem_req, mem_addr, instr_valid, instr, instr_pc, instr_misalign
  );

  modport slave (
    output pc_in, flush, mem_rvalid, mem_rdata, instr_ready,
    input  pc_stall, mem_req, mem_addr, instr_valid, instr, instr_pc, instr_misalign
  );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetcher feeding a DEPTH-entry buffer to decode.
// Flush drops both the buffer and any read still in flight.
module instruction_fetch #(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_fetch_if.master  if_fetch
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                   r_state, w_state_nxt;
  logic [CW-1:0]            r_count;
  logic [PW-1:0]            r_wptr, r_rptr;
  logic [31:0]              r_pc_lat;
  logic [DEPTH-1:0][31:0]   r_data;
  logic [DEPTH-1:0][31:0]   r_pc;
  logic [DEPTH-1:0]         r_mis;
  logic                     w_issue, w_push, w_pop;

  // Gated by rst_n so no request escapes while reset is held.
  assign w_issue = rst_n && (r_state == IDLE) && !if_fetch.flush
                   && (r_count < CW'(DEPTH));
  assign w_pop   = (r_count != '0) && if_fetch.instr_ready && !if_fetch.flush;

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      IDLE: if (w_issue) w_state_nxt = WAIT;
      WAIT: begin
        if (if_fetch.flush)
          w_state_nxt = if_fetch.mem_rvalid ? IDLE : DROP;
        else if (if_fetch.mem_rvalid) begin
          w_state_nxt = IDLE;
          w_push      = 1'b1;
        end
      end
      DROP: if (if_fetch.mem_rvalid) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc_lat <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) r_pc_lat <= if_fetch.pc_in;
    end
  end

  // Issue only happens with count < DEPTH and pops only shrink it while WAIT,
  // so a push never finds the buffer full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (if_fetch.flush) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_pc   <= '0;
      r_mis  <= '0;
    end else if (w_push) begin
      r_data[r_wptr] <= if_fetch.mem_rdata;
      r_pc[r_wptr]   <= r_pc_lat;
      r_mis[r_wptr]  <= (r_pc_lat[1:0] != 2'b00);
    end
  end

  assign if_fetch.mem_req        = w_issue;
  assign if_fetch.pc_stall       = !w_issue;
  assign if_fetch.mem_addr       = if_fetch.pc_in;
  assign if_fetch.instr_valid    = (r_count != '0);
  assign if_fetch.instr          = r_data[r_rptr];
  assign if_fetch.instr_pc       = r_pc[r_rptr];
  assign if_fetch.instr_misalign = r_mis[r_rptr];
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: memory model queues expected entries
// when it answers a read; decode-side pops are compared against the queue.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b1;

  instruction_fetch_if bus();
  instruction_fetch #(.DEPTH(2)) dut (.clk(clk), .rst_n(rst_n), .if_fetch(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        mis;
    int          rc;
  } ent_t;

  ent_t        sb[$];
  ent_t        e;
  int          total = 0, bad = 0, cyc = 0, req_cnt = 0, pop_cnt = 0, p0 = 0;
  bit          auto_mem = 1'b1, auto_pc = 1'b1, chk_lat = 1'b0;
  int          lat = 1, pend_left = 0, pend_rc = 0;
  logic [31:0] pend_pc = '0, pc_next = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0013 ^ (a << 8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Observe at the falling edge: decode pops and new memory requests.
  task automatic sample();
    @(negedge clk);
    pc_next = bus.pc_in;
    if (rst_n && bus.instr_valid && bus.instr_ready && !bus.flush) begin
      if (sb.size() == 0) chk("pop_unexpected", 32'(bus.instr_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("instr", bus.instr, e.data);
        chk("instr_pc", bus.instr_pc, e.pc);
        chk("instr_mis", 32'(bus.instr_misalign), 32'(e.mis));
        if (chk_lat) chk("latency", cyc - e.rc, 2);
        pop_cnt++;
      end
    end
    if (rst_n && bus.mem_req) begin
      req_cnt++;
      chk("mem_addr", bus.mem_addr, bus.pc_in);
      if (auto_mem) begin
        pend_left = lat;
        pend_pc   = bus.pc_in;
        pend_rc   = cyc;
      end
      if (auto_pc) pc_next = bus.pc_in + 32'd4;
    end
  endtask

  // Step past the rising edge and drive the memory response / next pc.
  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    bus.mem_rvalid = 1'b0;
    bus.pc_in      = pc_next;
    if (pend_left > 0) begin
      pend_left--;
      if (pend_left == 0) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_word(pend_pc);
        sb.push_back('{mem_word(pend_pc), pend_pc, (pend_pc[1:0] != 2'b00), pend_rc});
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic do_reset(input logic [31:0] pc);
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.instr_ready = 1'b1;
    bus.pc_in = pc;
    pend_left = 0;
    sb.delete();
    sample();
    advance();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.pc_in = '0; bus.flush = 1'b0; bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0; bus.instr_ready = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    sample();
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_pc_stall", 32'(bus.pc_stall), 32'd1);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_instr_pc", bus.instr_pc, 32'd0);
    chk("rst_mis", 32'(bus.instr_misalign), 32'd0);
    advance();
    rst_n = 1'b1;

    // Streaming, 1-cycle memory, decode always ready
    chk_lat = 1'b1;
    req_cnt = 0;
    sample();
    chk("first_req", 32'(bus.mem_req), 32'd1);
    chk("first_addr", bus.mem_addr, 32'd0);
    chk("first_stall", 32'(bus.pc_stall), 32'd0);
    advance();
    step(11);
    chk("stream_reqs", req_cnt, 6);
    chk_lat = 1'b0;

    // Backpressure: buffer fills, fetch stalls, head holds
    bus.instr_ready = 1'b0;
    step(8);
    sample();
    chk("bp_req", 32'(bus.mem_req), 32'd0);
    chk("bp_stall", 32'(bus.pc_stall), 32'd1);
    chk("bp_valid", 32'(bus.instr_valid), 32'd1);
    chk("bp_sb", sb.size(), 2);
    if (sb.size() > 0) begin
      chk("bp_instr", bus.instr, sb[0].data);
      chk("bp_pc", bus.instr_pc, sb[0].pc);
    end
    advance();
    step(3);
    sample();
    if (sb.size() > 0) begin
      chk("bp_hold_instr", bus.instr, sb[0].data);
      chk("bp_hold_pc", bus.instr_pc, sb[0].pc);
    end
    advance();
    bus.instr_ready = 1'b1;
    step(1);
    bus.instr_ready = 1'b0;
    bus.flush = 1'b1;
    sample();
    chk("fl_full_req", 32'(bus.mem_req), 32'd0);
    advance();
    sb.delete();
    bus.flush = 1'b0;
    sample();
    chk("fl_full_valid", 32'(bus.instr_valid), 32'd0);
    chk("fl_full_req2", 32'(bus.mem_req), 32'd1);
    advance();
    bus.instr_ready = 1'b1;
    step(6);

    // Flush while a read is outstanding; late data dropped
    auto_mem = 1'b0; auto_pc = 1'b0;
    do_reset(32'h8);
    sample();
    chk("fw_req", 32'(bus.mem_req), 32'd1);
    chk("fw_addr", bus.mem_addr, 32'h8);
    advance();
    bus.flush = 1'b1;
    bus.pc_in = 32'h100;
    sample();
    chk("fw_req_flush", 32'(bus.mem_req), 32'd0);
    chk("fw_stall", 32'(bus.pc_stall), 32'd1);
    advance();
    bus.flush = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    sample();
    chk("fw_drop_req", 32'(bus.mem_req), 32'd0);
    advance();
    sample();
    chk("fw_valid", 32'(bus.instr_valid), 32'd0);
    chk("fw_new_req", 32'(bus.mem_req), 32'd1);
    chk("fw_new_addr", bus.mem_addr, 32'h100);
    advance();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = mem_word(32'h100);
    sb.push_back('{mem_word(32'h100), 32'h100, 1'b0, 0});
    p0 = pop_cnt;
    step(2);
    chk("fw_pops", pop_cnt - p0, 1);

    // Flush in the same cycle as rvalid; buffer also cleared
    do_reset(32'h20);
    bus.instr_ready = 1'b0;
    sample();
    advance();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = mem_word(32'h20);
    bus.pc_in = 32'h24;
    sample();
    advance();
    sample();
    chk("fr_pre_valid", 32'(bus.instr_valid), 32'd1);
    chk("fr_pre_addr", bus.mem_addr, 32'h24);
    advance();
    bus.flush = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    sample();
    chk("fr_req", 32'(bus.mem_req), 32'd0);
    advance();
    bus.flush = 1'b0;
    sample();
    chk("fr_valid", 32'(bus.instr_valid), 32'd0);
    chk("fr_idle_req", 32'(bus.mem_req), 32'd1);
    advance();

    // Misaligned fetch address
    auto_mem = 1'b1;
    do_reset(32'h6);
    p0 = pop_cnt;
    step(6);
    chk("mis_pops", pop_cnt - p0, 2);

    // Reset while a read is outstanding
    auto_mem = 1'b0;
    do_reset(32'h40);
    sample();
    chk("rw_req", 32'(bus.mem_req), 32'd1);
    advance();
    rst_n = 1'b0;
    sample();
    chk("rw_req_rst", 32'(bus.mem_req), 32'd0);
    chk("rw_valid_rst", 32'(bus.instr_valid), 32'd0);
    chk("rw_instr_rst", bus.instr, 32'd0);
    chk("rw_pc_rst", bus.instr_pc, 32'd0);
    advance();
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'h0BAD_0BAD;
    bus.pc_in = 32'h44;
    sample();
    chk("rw_new_req", 32'(bus.mem_req), 32'd1);
    chk("rw_new_addr", bus.mem_addr, 32'h44);
    advance();
    sample();
    chk("rw_ignored", 32'(bus.instr_valid), 32'd0);
    advance();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = mem_word(32'h44);
    sb.push_back('{mem_word(32'h44), 32'h44, 1'b0, 0});
    p0 = pop_cnt;
    step(2);
    chk("rw_pops", pop_cnt - p0, 1);
    chk("end_sb", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
